// File: rtl/bu2020_pkg.sv
// Shared BU2020 data-memory widths and the arbiter FSM state encoding.
package bu2020_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } mpa_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: combinational winner from req and the last owner.
// On a tie the port that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       any_o,
  output logic       winner_o
);

  assign any_o = |req_i;

  always_comb begin
    winner_o = 1'b0;
    if (req_i == 2'b11) begin
      winner_o = ~last_owner_i;
    end else begin
      winner_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the BU2020 data-memory port between the LSU (port 0) and the loader (port 1).
// One access in flight: grant one cycle after request, read data RD_LAT cycles after grant.
module mem_port_arbiter #(
  parameter int ADDR_W = bu2020_pkg::ADDR_W,
  parameter int DATA_W = bu2020_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  import bu2020_pkg::*;

  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(RD_LAT - 1);

  mpa_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;

  logic              any_req;
  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        winner_oh;
  logic [1:0]        owner_oh;

  rr_arbiter2 u_arb (
    .req_i        (req),
    .last_owner_i (owner_q),
    .any_o        (any_req),
    .winner_o     (winner)
  );

  assign sel_we    = winner ? we[1]  : we[0];
  assign sel_addr  = winner ? addr1  : addr0;
  assign sel_wdata = winner ? wdata1 : wdata0;
  assign winner_oh = winner  ? 2'b10 : 2'b01;
  assign owner_oh  = owner_q ? 2'b10 : 2'b01;

  // Every output is a register, so reset clears them all without waiting for a clock.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    err_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          gnt_d   = winner_oh;
          if (sel_addr[0]) begin
            err_d = winner_oh;
          end else begin
            state_d     = ACCESS;
            we_d        = sel_we;
            cnt_d       = '0;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_write_d = sel_we;
          end
        end
      end

      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else if (RD_LAT == 1) begin
          rdata_d  = mem_rdata;
          rvalid_d = owner_oh;
          state_d  = IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RDWAIT;
        end
      end

      RDWAIT: begin
        if (cnt_q == LAST_CNT) begin
          rdata_d  = mem_rdata;
          rvalid_d = owner_oh;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Last owner resets to port 1 so that port 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      err_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign gnt       = gnt_q;
  assign err       = err_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with RD_LAT=1 (index 0), one with RD_LAT=3 (index 1).
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    int          kind;   // 0 gnt, 1 err, 2 rvalid, 3 mem_write
    int          port;
    logic [15:0] dat;
  } ev_t;

  typedef struct {
    int          k;
    int          p;
    bit          we;
    logic [11:0] addr;
    logic [15:0] wd;
    bit          e_err;
    bit          e_wr;
    int          e_rvc;
    logic [15:0] e_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_mem = 1'b1;

  logic [1:0][1:0]  req_s, we_s, gnt_s, rvalid_s, err_s;
  logic [1:0][11:0] addr0_s, addr1_s, mem_addr_s;
  logic [1:0][15:0] wdata0_s, wdata1_s, rdata_s, mem_wdata_s, mem_rdata_s;
  logic [1:0]       mem_write_s;

  logic [15:0] mem  [2][2048];
  logic [15:0] refm [2][2048];
  int          last_own [2];

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  nvec = 0;
  int  nerr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]),
    .addr0(addr0_s[0]), .addr1(addr1_s[0]), .wdata0(wdata0_s[0]), .wdata1(wdata1_s[0]),
    .gnt(gnt_s[0]), .rvalid(rvalid_s[0]), .rdata(rdata_s[0]), .err(err_s[0]),
    .mem_addr(mem_addr_s[0]), .mem_wdata(mem_wdata_s[0]), .mem_write(mem_write_s[0]),
    .mem_rdata(mem_rdata_s[0])
  );

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]),
    .addr0(addr0_s[1]), .addr1(addr1_s[1]), .wdata0(wdata0_s[1]), .wdata1(wdata1_s[1]),
    .gnt(gnt_s[1]), .rvalid(rvalid_s[1]), .rdata(rdata_s[1]), .err(err_s[1]),
    .mem_addr(mem_addr_s[1]), .mem_wdata(mem_wdata_s[1]), .mem_write(mem_write_s[1]),
    .mem_rdata(mem_rdata_s[1])
  );

  function automatic logic [15:0] pat(input int k, input int i);
    return 16'(i * 313 + k * 7919) ^ 16'hA5C3;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic ev_t mk(input int c, input int kind, input int p, input logic [15:0] d);
    ev_t e;
    e.cyc = c; e.kind = kind; e.port = p; e.dat = d;
    return e;
  endfunction

  // Memory behind each DUT: combinational read, write on the strobe edge.
  assign mem_rdata_s[0] = mem[0][mem_addr_s[0][11:1]];
  assign mem_rdata_s[1] = mem[1][mem_addr_s[1][11:1]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 2048; i++) mem[k][i] <= pat(k, i);
    end else begin
      for (int k = 0; k < 2; k++)
        if (mem_write_s[k]) mem[k][mem_addr_s[k][11:1]] <= mem_wdata_s[k];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic set_port(input int k, input int p, input bit w, input logic [11:0] a,
                          input logic [15:0] d);
    we_s[k][p] = w;
    if (p == 0) begin addr0_s[k] = a; wdata0_s[k] = d; end
    else        begin addr1_s[k] = a; wdata1_s[k] = d; end
    req_s[k][p] = 1'b1;
  endtask

  // Observe ncyc cycles after the request cycle; a requester drops req once granted unless hold.
  task automatic watch(input int k, input int ncyc, input bit hold);
    obs_q.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (gnt_s[k][p]) begin
          obs_q.push_back(mk(c, 0, p, err_s[k][p] ? 16'h0 : {4'h0, mem_addr_s[k]}));
          if (!hold) req_s[k][p] = 1'b0;
        end
        if (err_s[k][p])    obs_q.push_back(mk(c, 1, p, 16'h0));
        if (rvalid_s[k][p]) obs_q.push_back(mk(c, 2, p, rdata_s[k]));
      end
      if (mem_write_s[k]) obs_q.push_back(mk(c, 3, 0, mem_wdata_s[k]));
    end
    req_s[k] = 2'b00;
  endtask

  task automatic cmp_ev(input string nm);
    nvec++;
    if (obs_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL %s event count: got %0d expected %0d", nm, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].kind != exp_q[i].kind ||
          obs_q[i].port != exp_q[i].port || obs_q[i].dat !== exp_q[i].dat) begin
        nerr++;
        $display("FAIL %s ev%0d: got cyc%0d kind%0d port%0d dat %h expected cyc%0d kind%0d port%0d dat %h",
                 nm, i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].port, obs_q[i].dat,
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].port, exp_q[i].dat);
      end
    end
  endtask

  task automatic chk_zero(input int k, input string nm);
    chk({nm, "_gnt"},       32'(gnt_s[k]),       32'h0);
    chk({nm, "_rvalid"},    32'(rvalid_s[k]),    32'h0);
    chk({nm, "_err"},       32'(err_s[k]),       32'h0);
    chk({nm, "_rdata"},     32'(rdata_s[k]),     32'h0);
    chk({nm, "_mem_addr"},  32'(mem_addr_s[k]),  32'h0);
    chk({nm, "_mem_wdata"}, 32'(mem_wdata_s[k]), 32'h0);
    chk({nm, "_mem_write"}, 32'(mem_write_s[k]), 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   mask, first, n, t, p;
    bit          we_r [2];
    logic [11:0] ad_r [2];
    logic [15:0] wd_r [2];

    req_s = '0; we_s = '0; addr0_s = '0; addr1_s = '0; wdata0_s = '0; wdata1_s = '0;
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    chk_zero(0, "reset_lat1");
    chk_zero(1, "reset_lat3");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single transactions with hand-derived expectations
    tbl[0] = '{0, 0, 1'b1, 12'hFFE, 16'hAAAA, 1'b0, 1'b1, 0, 16'h0};
    tbl[1] = '{0, 0, 1'b0, 12'hFFE, 16'h0,    1'b0, 1'b0, 2, 16'hAAAA};
    tbl[2] = '{0, 1, 1'b1, 12'hFFC, 16'h1234, 1'b0, 1'b1, 0, 16'h0};
    tbl[3] = '{0, 1, 1'b1, 12'hFFD, 16'hBBBB, 1'b1, 1'b0, 0, 16'h0};
    tbl[4] = '{0, 1, 1'b0, 12'hFFC, 16'h0,    1'b0, 1'b0, 2, 16'h1234};
    tbl[5] = '{1, 1, 1'b1, 12'hFFA, 16'hCCCC, 1'b0, 1'b1, 0, 16'h0};
    tbl[6] = '{1, 1, 1'b0, 12'hFFA, 16'h0,    1'b0, 1'b0, 4, 16'hCCCC};
    tbl[7] = '{1, 0, 1'b1, 12'h000, 16'h5A5A, 1'b0, 1'b1, 0, 16'h0};
    tbl[8] = '{1, 0, 1'b0, 12'h000, 16'h0,    1'b0, 1'b0, 4, 16'h5A5A};
    tbl[9] = '{1, 0, 1'b0, 12'h003, 16'h0,    1'b1, 1'b0, 0, 16'h0};

    for (int i = 0; i < 10; i++) begin
      exp_q.delete();
      exp_q.push_back(mk(1, 0, tbl[i].p, tbl[i].e_err ? 16'h0 : {4'h0, tbl[i].addr}));
      if (tbl[i].e_err)     exp_q.push_back(mk(1, 1, tbl[i].p, 16'h0));
      if (tbl[i].e_wr)      exp_q.push_back(mk(1, 3, 0, tbl[i].wd));
      if (tbl[i].e_rvc > 0) exp_q.push_back(mk(tbl[i].e_rvc, 2, tbl[i].p, tbl[i].e_rd));
      set_port(tbl[i].k, tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].wd);
      watch(tbl[i].k, 8, 1'b0);
      cmp_ev($sformatf("tbl%0d", i));
    end
    chk("misaligned_no_write_FFC", 32'(mem[0][12'hFFC >> 1]), 32'h1234);

    // Continuous contention on RD_LAT=1: strict alternation starting with port 0
    pulse_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      p = i % 2;
      exp_q.push_back(mk(1 + 2 * i, 0, p, p ? 16'h020 : 16'h010));
      exp_q.push_back(mk(2 + 2 * i, 2, p, pat(0, p ? 16 : 8)));
    end
    set_port(0, 0, 1'b0, 12'h010, 16'h0);
    set_port(0, 1, 1'b0, 12'h020, 16'h0);
    watch(0, 8, 1'b1);
    cmp_ev("contend");

    // RD_LAT=3: address held through RDWAIT, port 0 deferred until rvalid cycle
    set_port(1, 1, 1'b0, 12'hFFA, 16'h0);
    @(posedge clk); #1;
    chk("lat3_c1_gnt", 32'(gnt_s[1]), 32'h2);
    chk("lat3_c1_addr", 32'(mem_addr_s[1]), 32'hFFA);
    chk("lat3_c1_write", 32'(mem_write_s[1]), 32'h0);
    req_s[1][1] = 1'b0;
    set_port(1, 0, 1'b0, 12'h000, 16'h0);
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("lat3_c%0d_addr", c), 32'(mem_addr_s[1]), 32'hFFA);
      chk($sformatf("lat3_c%0d_gnt", c), 32'(gnt_s[1]), 32'h0);
      chk($sformatf("lat3_c%0d_rvalid", c), 32'(rvalid_s[1]), 32'h0);
    end
    @(posedge clk); #1;
    chk("lat3_c4_rvalid", 32'(rvalid_s[1]), 32'h2);
    chk("lat3_c4_rdata", 32'(rdata_s[1]), 32'hCCCC);
    chk("lat3_c4_gnt", 32'(gnt_s[1]), 32'h0);
    @(posedge clk); #1;
    chk("lat3_c5_gnt", 32'(gnt_s[1]), 32'h1);
    chk("lat3_c5_addr", 32'(mem_addr_s[1]), 32'h000);
    req_s[1] = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("lat3_c8_rvalid", 32'(rvalid_s[1]), 32'h1);
    chk("lat3_c8_rdata", 32'(rdata_s[1]), 32'h5A5A);

    // Asynchronous reset while in RDWAIT
    @(posedge clk); #1;
    set_port(1, 1, 1'b0, 12'hFFA, 16'h0);
    @(posedge clk); #1;
    req_s[1] = 2'b00;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_zero(1, "midread_rst");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    watch(1, 6, 1'b0);
    cmp_ev("no_rvalid_after_rst");
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 16'h000));
    exp_q.push_back(mk(4, 2, 0, 16'h5A5A));
    exp_q.push_back(mk(5, 0, 1, 16'hFFA));
    exp_q.push_back(mk(8, 2, 1, 16'hCCCC));
    set_port(1, 0, 1'b0, 12'h000, 16'h0);
    set_port(1, 1, 1'b0, 12'hFFA, 16'h0);
    watch(1, 10, 1'b0);
    cmp_ev("tie_after_rst");

    // Randomised transactions against a transaction-level model
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      last_own[k] = 1;
      for (int i = 0; i < 2048; i++) refm[k][i] = mem[k][i];
    end
    for (int r = 0; r < 80; r++) begin
      int k;
      k = r % 2;
      mask = $urandom_range(1, 3);
      for (int q = 0; q < 2; q++) begin
        we_r[q] = 1'($urandom_range(0, 1));
        ad_r[q] = 12'($urandom_range(0, 15) * 2 + (($urandom_range(0, 3) == 0) ? 1 : 0));
        wd_r[q] = 16'($urandom);
      end
      if (mask == 3) begin
        first = (last_own[k] == 1) ? 0 : 1;
        n = 2;
      end else begin
        first = (mask == 2) ? 1 : 0;
        n = 1;
      end
      exp_q.delete();
      t = 1;
      for (int j = 0; j < n; j++) begin
        p = (j == 0) ? first : 1 - first;
        if (ad_r[p][0]) begin
          exp_q.push_back(mk(t, 0, p, 16'h0));
          exp_q.push_back(mk(t, 1, p, 16'h0));
          t = t + 1;
        end else if (we_r[p]) begin
          exp_q.push_back(mk(t, 0, p, {4'h0, ad_r[p]}));
          exp_q.push_back(mk(t, 3, 0, wd_r[p]));
          refm[k][ad_r[p] >> 1] = wd_r[p];
          t = t + 2;
        end else begin
          exp_q.push_back(mk(t, 0, p, {4'h0, ad_r[p]}));
          exp_q.push_back(mk(t + lat_of(k), 2, p, refm[k][ad_r[p] >> 1]));
          t = t + lat_of(k) + 1;
        end
        last_own[k] = p;
      end
      for (int q = 0; q < 2; q++)
        if (mask[q]) set_port(k, q, we_r[q], ad_r[q], wd_r[q]);
      watch(k, 12, 1'b0);
      cmp_ev($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
